alu_exec_mc: RTL and testbench

Parametrised successor to the single-cycle ALU decoder. It decodes the full RV32I ALU operation set, widening alu_control from 3 to 4 bits while keeping the legacy 3-bit codes. It adds the M-extension (MUL/DIV/REM) as an iterative multi-cycle datapath. It sits between the main decoder and writeback, with valid/ready handshakes on both sides, and is the execute stage of the multi-cycle core.

---
 rtl/alu_exec_mc.sv | 264 ++++++++++++++++++++++++++
 tb/tb_alu_exec_mc.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_mc.sv
// alu_exec_mc: RV32I ALU execute stage with valid/ready handshakes on both sides.
// Define ALU_MEXT_EN to add the iterative M-extension (MUL/DIV/REM) datapath.
module alu_exec_mc #(
  parameter  int unsigned XLEN = 32,
  localparam int unsigned SHW  = $clog2(XLEN)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [1:0]      alu_op_i,
  input  logic [2:0]      funct3_i,
  input  logic            funct7_5_i,
  input  logic            funct7_0_i,
  input  logic            op_5_i,
  input  logic [XLEN-1:0] src_a_i,
  input  logic [XLEN-1:0] src_b_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o,
  output logic [3:0]      alu_control_o,
  output logic            busy_o
);

  localparam logic [3:0] CTL_ADD   = 4'b0000;
  localparam logic [3:0] CTL_SUB   = 4'b0001;
  localparam logic [3:0] CTL_AND   = 4'b0010;
  localparam logic [3:0] CTL_OR    = 4'b0011;
  localparam logic [3:0] CTL_XOR   = 4'b0100;
  localparam logic [3:0] CTL_SLT   = 4'b0101;
  localparam logic [3:0] CTL_SLTU  = 4'b0110;
  localparam logic [3:0] CTL_SLL   = 4'b0111;
  localparam logic [3:0] CTL_SRL   = 4'b1000;
  localparam logic [3:0] CTL_SRA   = 4'b1001;
  localparam logic [3:0] CTL_PASSB = 4'b1010;
  localparam logic [3:0] CTL_MDU   = 4'b1111;

`ifdef ALU_MEXT_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_e;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd2} state_e;
`endif

  state_e          state_q, state_n;
  logic [3:0]      ctrl_c;
  logic [XLEN-1:0] alu_c;
  logic [SHW-1:0]  shamt_c;
  logic [XLEN-1:0] result_q, result_n;
  logic            zero_q, zero_n;
  logic [3:0]      ctrl_q, ctrl_n;
  logic            valid_q, ready_q;

  // Decode main-decoder class and funct fields into a 4-bit control code
  always_comb begin
    ctrl_c = CTL_ADD;
    case (alu_op_i)
      2'b00: ctrl_c = CTL_ADD;
      2'b01: ctrl_c = CTL_SUB;
      2'b11: ctrl_c = CTL_PASSB;
      default: begin
        case (funct3_i)
          3'b000:  ctrl_c = (op_5_i && funct7_5_i) ? CTL_SUB : CTL_ADD;
          3'b001:  ctrl_c = CTL_SLL;
          3'b010:  ctrl_c = CTL_SLT;
          3'b011:  ctrl_c = CTL_SLTU;
          3'b100:  ctrl_c = CTL_XOR;
          3'b101:  ctrl_c = funct7_5_i ? CTL_SRA : CTL_SRL;
          3'b110:  ctrl_c = CTL_OR;
          default: ctrl_c = CTL_AND;
        endcase
`ifdef ALU_MEXT_EN
        if (op_5_i && funct7_0_i) ctrl_c = CTL_MDU;
`endif
      end
    endcase
  end

  // Single-cycle ALU on the live request operands
  always_comb begin
    alu_c   = '0;
    shamt_c = src_b_i[SHW-1:0];
    case (ctrl_c)
      CTL_ADD:   alu_c = src_a_i + src_b_i;
      CTL_SUB:   alu_c = src_a_i - src_b_i;
      CTL_AND:   alu_c = src_a_i & src_b_i;
      CTL_OR:    alu_c = src_a_i | src_b_i;
      CTL_XOR:   alu_c = src_a_i ^ src_b_i;
      CTL_SLT:   alu_c = {{(XLEN-1){1'b0}}, ($signed(src_a_i) < $signed(src_b_i))};
      CTL_SLTU:  alu_c = {{(XLEN-1){1'b0}}, (src_a_i < src_b_i)};
      CTL_SLL:   alu_c = src_a_i << shamt_c;
      CTL_SRL:   alu_c = src_a_i >> shamt_c;
      CTL_SRA:   alu_c = XLEN'($signed(src_a_i) >>> shamt_c);
      CTL_PASSB: alu_c = src_b_i;
      default:   alu_c = '0;
    endcase
  end

`ifdef ALU_MEXT_EN
  localparam int unsigned CW = SHW + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [XLEN-1:0]   hi_q, hi_n, lo_q, lo_n, opnd_q, opnd_n;
  logic [CW-1:0]     cnt_q, cnt_n;
  logic              neg_q, neg_n;
  logic [2:0]        mop_q, mop_n;
  logic              busy_q;
  logic              sgn_a_c, sgn_b_c, sa_c, sb_c, spec_c;
  logic [XLEN-1:0]   abs_a_c, abs_b_c, spec_res_c;
  logic [XLEN:0]     acc_c, rsh_c, diff_c;
  logic [XLEN-1:0]   step_hi_c, step_lo_c, qr_c, fix_c;
  logic [2*XLEN-1:0] prod_c;

  // Accept-time prep: operand magnitudes, result sign, divide special cases
  always_comb begin
    sgn_a_c    = funct3_i[2] ? !funct3_i[0] : (funct3_i[1:0] != 2'b11);
    sgn_b_c    = funct3_i[2] ? !funct3_i[0] : !funct3_i[1];
    sa_c       = sgn_a_c && src_a_i[XLEN-1];
    sb_c       = sgn_b_c && src_b_i[XLEN-1];
    abs_a_c    = sa_c ? -src_a_i : src_a_i;
    abs_b_c    = sb_c ? -src_b_i : src_b_i;
    spec_c     = 1'b0;
    spec_res_c = '0;
    if (funct3_i[2]) begin
      if (src_b_i == '0) begin
        spec_c     = 1'b1;
        spec_res_c = funct3_i[1] ? src_a_i : '1;
      end else if (!funct3_i[0] && (src_a_i == MIN_NEG) && (src_b_i == '1)) begin
        spec_c     = 1'b1;
        spec_res_c = funct3_i[1] ? '0 : MIN_NEG;
      end
    end
  end

  // One radix-2 step (shift-add multiply or restoring divide) plus final sign fix
  always_comb begin
    acc_c  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    rsh_c  = {hi_q, lo_q[XLEN-1]};
    diff_c = rsh_c - {1'b0, opnd_q};
    if (mop_q[2]) begin
      step_hi_c = diff_c[XLEN] ? rsh_c[XLEN-1:0] : diff_c[XLEN-1:0];
      step_lo_c = {lo_q[XLEN-2:0], ~diff_c[XLEN]};
    end else begin
      step_hi_c = acc_c[XLEN:1];
      step_lo_c = {acc_c[0], lo_q[XLEN-1:1]};
    end
    prod_c = {step_hi_c, step_lo_c};
    if (neg_q) prod_c = -prod_c;
    qr_c = mop_q[1] ? step_hi_c : step_lo_c;
    if (neg_q) qr_c = -qr_c;
    if (mop_q[2])                fix_c = qr_c;
    else if (mop_q[1:0] == 2'b00) fix_c = prod_c[XLEN-1:0];
    else                          fix_c = prod_c[2*XLEN-1:XLEN];
  end
`else
  logic unused_c;
  assign unused_c = funct7_0_i;
`endif

  // Next-state and next-register values
  always_comb begin
    state_n  = state_q;
    result_n = result_q;
    ctrl_n   = ctrl_q;
`ifdef ALU_MEXT_EN
    hi_n   = hi_q;
    lo_n   = lo_q;
    opnd_n = opnd_q;
    cnt_n  = cnt_q;
    neg_n  = neg_q;
    mop_n  = mop_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          ctrl_n   = ctrl_c;
          result_n = alu_c;
          state_n  = S_DONE;
`ifdef ALU_MEXT_EN
          if (ctrl_c == CTL_MDU) begin
            mop_n = funct3_i;
            neg_n = (funct3_i[2] && funct3_i[1]) ? sa_c : (sa_c ^ sb_c);
            if (spec_c) begin
              result_n = spec_res_c;
            end else begin
              state_n = S_CALC;
              cnt_n   = CW'(XLEN);
              hi_n    = '0;
              lo_n    = funct3_i[2] ? abs_a_c : abs_b_c;
              opnd_n  = funct3_i[2] ? abs_b_c : abs_a_c;
            end
          end
`endif
        end
      end
`ifdef ALU_MEXT_EN
      S_CALC: begin
        hi_n  = step_hi_c;
        lo_n  = step_lo_c;
        cnt_n = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          result_n = fix_c;
          state_n  = S_DONE;
        end
      end
`endif
      S_DONE: begin
        if (ready_i) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    zero_n = (result_n == '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      ctrl_q   <= '0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_n;
      result_q <= result_n;
      zero_q   <= zero_n;
      ctrl_q   <= ctrl_n;
      valid_q  <= (state_n == S_DONE);
      ready_q  <= (state_n == S_IDLE);
    end
  end

`ifdef ALU_MEXT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      neg_q  <= 1'b0;
      mop_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      hi_q   <= hi_n;
      lo_q   <= lo_n;
      opnd_q <= opnd_n;
      cnt_q  <= cnt_n;
      neg_q  <= neg_n;
      mop_q  <= mop_n;
      busy_q <= (state_n == S_CALC);
    end
  end
  assign busy_o = busy_q;
`else
  assign busy_o = 1'b0;
`endif

  assign ready_o       = ready_q;
  assign valid_o       = valid_q;
  assign result_o      = result_q;
  assign zero_o        = zero_q;
  assign alu_control_o = ctrl_q;

endmodule

// File: tb/tb_alu_exec_mc.sv
// Self-checking bench for alu_exec_mc; expected results queued at issue, compared at output.
module tb_alu_exec_mc;
  localparam int unsigned XLEN = 32;
  localparam int MDU_LAT = XLEN + 1;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            valid_i;
  logic            ready_o;
  logic [1:0]      alu_op_i;
  logic [2:0]      funct3_i;
  logic            funct7_5_i;
  logic            funct7_0_i;
  logic            op_5_i;
  logic [XLEN-1:0] src_a_i;
  logic [XLEN-1:0] src_b_i;
  logic            valid_o;
  logic            ready_i;
  logic [XLEN-1:0] result_o;
  logic            zero_o;
  logic [3:0]      alu_control_o;
  logic            busy_o;

  typedef struct {
    logic [3:0]      ctl;
    logic [XLEN-1:0] res;
    int              lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  alu_exec_mc #(.XLEN(XLEN)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .alu_op_i(alu_op_i), .funct3_i(funct3_i), .funct7_5_i(funct7_5_i),
    .funct7_0_i(funct7_0_i), .op_5_i(op_5_i), .src_a_i(src_a_i), .src_b_i(src_b_i),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o), .zero_o(zero_o),
    .alu_control_o(alu_control_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one request, scramble inputs after accept, then pop and compare the result
  task automatic do_op(input string tag, input logic [1:0] op, input logic [2:0] f3,
                       input logic f75, input logic f70, input logic o5,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [3:0] ectl, input logic [XLEN-1:0] eres,
                       input int elat, input int stall);
    exp_t e;
    int   lat;
    int   nbusy;
    @(negedge clk_i);
    check({tag, "_rdy"}, 64'(ready_o), 64'd1);
    alu_op_i = op; funct3_i = f3; funct7_5_i = f75; funct7_0_i = f70; op_5_i = o5;
    src_a_i = a; src_b_i = b; valid_i = 1'b1;
    sb_q.push_back('{ectl, eres, elat});
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    src_a_i = $urandom; src_b_i = $urandom; funct3_i = 3'($urandom); alu_op_i = 2'($urandom);
    lat = 1;
    nbusy = 0;
    while (!valid_o && lat < 200) begin
      nbusy += int'(busy_o);
      @(posedge clk_i); #1;
      lat++;
    end
    e = sb_q.pop_front();
    check({tag, "_lat"},  64'(lat), 64'(e.lat));
    check({tag, "_busy"}, 64'(nbusy), 64'(e.lat - 1));
    check({tag, "_res"},  64'(result_o), 64'(e.res));
    check({tag, "_zero"}, 64'(zero_o), 64'(e.res == '0));
    check({tag, "_ctl"},  64'(alu_control_o), 64'(e.ctl));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk_i);
      valid_i = 1'b1; src_a_i = $urandom; src_b_i = $urandom;
      @(posedge clk_i); #1;
      check({tag, "_stall_v"},   64'(valid_o), 64'd1);
      check({tag, "_stall_res"}, 64'(result_o), 64'(e.res));
      check({tag, "_stall_rdy"}, 64'(ready_o), 64'd0);
    end
    @(negedge clk_i);
    valid_i = 1'b0; ready_i = 1'b1;
    @(posedge clk_i); #1;
    ready_i = 1'b0;
    check({tag, "_hs_v"},   64'(valid_o), 64'd0);
    check({tag, "_hs_rdy"}, 64'(ready_o), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0; valid_i = 1'b1; ready_i = 1'b0;
    alu_op_i = 2'b10; funct3_i = 3'b000; funct7_5_i = 1'b0; funct7_0_i = 1'b0;
    op_5_i = 1'b1; src_a_i = 32'd5; src_b_i = 32'd7;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_ready", 64'(ready_o), 64'd1);
    check("rst_res",   64'(result_o), 64'd0);
    check("rst_zero",  64'(zero_o), 64'd0);
    check("rst_ctl",   64'(alu_control_o), 64'd0);
    check("rst_busy",  64'(busy_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1; valid_i = 1'b0;

    do_op("sub",   2'b10, 3'b000, 1, 0, 1, 32'd5, 32'd7, 4'b0001, 32'hFFFF_FFFE, 1, 0);
    do_op("add",   2'b10, 3'b000, 1, 0, 0, 32'd5, 32'd7, 4'b0000, 32'd12, 1, 0);
    do_op("sra",   2'b10, 3'b101, 1, 0, 1, 32'h8000_0000, 32'd4, 4'b1001, 32'hF800_0000, 1, 5);
    do_op("srl",   2'b10, 3'b101, 0, 0, 1, 32'h8000_0000, 32'd4, 4'b1000, 32'h0800_0000, 1, 0);
    do_op("srai",  2'b10, 3'b101, 1, 0, 0, 32'h8000_0000, 32'd4, 4'b1001, 32'hF800_0000, 1, 0);
    do_op("lui",   2'b11, 3'b000, 0, 0, 0, 32'hDEAD_BEEF, 32'h1234_5000, 4'b1010, 32'h1234_5000, 1, 0);
    do_op("ld_add",2'b00, 3'b010, 1, 0, 1, 32'h0000_1000, 32'hFFFF_FFFC, 4'b0000, 32'h0000_0FFC, 1, 0);
    do_op("br_sub",2'b01, 3'b000, 0, 0, 1, 32'd3, 32'd3, 4'b0001, 32'd0, 1, 0);
    do_op("slt",   2'b10, 3'b010, 0, 0, 1, 32'hFFFF_FFFF, 32'd1, 4'b0101, 32'd1, 1, 0);
    do_op("sltu",  2'b10, 3'b011, 0, 0, 1, 32'hFFFF_FFFF, 32'd1, 4'b0110, 32'd0, 1, 0);
    do_op("sll",   2'b10, 3'b001, 0, 0, 1, 32'd1, 32'h25, 4'b0111, 32'h20, 1, 0);
    do_op("xor",   2'b10, 3'b100, 0, 0, 1, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0100, 32'h0FF0_0FF0, 1, 0);
    do_op("or",    2'b10, 3'b110, 0, 0, 1, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0011, 32'hFFF0_FFF0, 1, 0);
    do_op("and",   2'b10, 3'b111, 0, 0, 1, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0010, 32'hF000_F000, 1, 0);

`ifdef ALU_MEXT_EN
    do_op("mul",    2'b10, 3'b000, 0, 1, 1, 32'hFFFF_FFFF, 32'd3, 4'b1111, 32'hFFFF_FFFD, MDU_LAT, 0);
    do_op("mulhu",  2'b10, 3'b011, 0, 1, 1, 32'hFFFF_FFFF, 32'd3, 4'b1111, 32'h0000_0002, MDU_LAT, 0);
    do_op("mulh",   2'b10, 3'b001, 0, 1, 1, 32'hFFFF_FFFF, 32'd3, 4'b1111, 32'hFFFF_FFFF, MDU_LAT, 0);
    do_op("mulhsu", 2'b10, 3'b010, 0, 1, 1, 32'hFFFF_FFFF, 32'd3, 4'b1111, 32'hFFFF_FFFF, MDU_LAT, 0);
    do_op("div0",   2'b10, 3'b100, 0, 1, 1, 32'd7, 32'd0, 4'b1111, 32'hFFFF_FFFF, 1, 0);
    do_op("rem0",   2'b10, 3'b110, 0, 1, 1, 32'd7, 32'd0, 4'b1111, 32'd7, 1, 0);
    do_op("divovf", 2'b10, 3'b100, 0, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 4'b1111, 32'h8000_0000, 1, 0);
    do_op("removf", 2'b10, 3'b110, 0, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 4'b1111, 32'd0, 1, 0);
    do_op("divu",   2'b10, 3'b101, 0, 1, 1, 32'd100, 32'd7, 4'b1111, 32'd14, MDU_LAT, 5);
    do_op("remu",   2'b10, 3'b111, 0, 1, 1, 32'd100, 32'd7, 4'b1111, 32'd2, MDU_LAT, 0);
    do_op("rem_n",  2'b10, 3'b110, 0, 1, 1, 32'hFFFF_FFF9, 32'd2, 4'b1111, 32'hFFFF_FFFF, MDU_LAT, 0);
    do_op("div_n",  2'b10, 3'b100, 0, 1, 1, 32'hFFFF_FFF9, 32'd2, 4'b1111, 32'hFFFF_FFFD, MDU_LAT, 0);
`else
    do_op("f70_ign", 2'b10, 3'b000, 0, 1, 1, 32'hFFFF_FFFF, 32'd3, 4'b0000, 32'd2, 1, 0);
    do_op("f70_xor", 2'b10, 3'b100, 0, 1, 1, 32'd100, 32'd7, 4'b0100, 32'd99, 1, 0);
`endif

    // Reset in flight: multiply in CALC when the M-extension is built, else a result held in DONE
    @(negedge clk_i);
    alu_op_i = 2'b10; funct3_i = 3'b000; funct7_5_i = 1'b0; funct7_0_i = 1'b1;
    op_5_i = 1'b1; src_a_i = 32'd9; src_b_i = 32'd9; valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #2;
`ifdef ALU_MEXT_EN
    check("mid_busy", 64'(busy_o), 64'd1);
`else
    check("mid_valid", 64'(valid_o), 64'd1);
`endif
    rst_ni = 1'b0;
    #1;
    check("mid_rst_valid", 64'(valid_o), 64'd0);
    check("mid_rst_busy",  64'(busy_o), 64'd0);
    check("mid_rst_ready", 64'(ready_o), 64'd1);
    check("mid_rst_res",   64'(result_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    do_op("post_rst", 2'b10, 3'b000, 1, 0, 1, 32'd20, 32'd8, 4'b0001, 32'd12, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
